instr_fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS core, directly upstream of the instruction decoder/control unit. It owns the program counter, issues word reads to instruction memory over a request/valid handshake, and holds the fetched word stable on `instr` for decode. It consumes the decoder's `Branch`/`Jump`/`jr_sel` results, resolved downstream into `branch_taken`/`jump`/`jr_sel`, to compute the next PC. It also flags fetch faults: memory timeout or misaligned target.

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-cycle word reads to imem, holds the fetched word for decode.
// Latency: request in cycle t, rvalid accepted from t+1, instr_valid from t+2; 3 cycles/instr at best.
// Backpressure: the word is held in VALID until advance=1; a memory timeout or misaligned target locks in ERR.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr_sel,
  input  logic [31:0] rs_value,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Last counter value allowed in WAIT; reaching it without rvalid is a fault.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_cnt;
  logic [31:0] w_next_pc;
  logic [31:0] w_br_off;
  logic [31:0] w_jmp_tgt;

  assign pc        = r_pc;
  assign instr     = r_instr;
  assign imem_addr = r_pc;
  assign pc_plus4  = r_pc + 32'd4;

  assign w_br_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jmp_tgt = {pc_plus4[31:28], r_instr[25:0], 2'b00};

  // Next-PC select: JR beats J/JAL beats taken branch beats sequential.
  always_comb begin
    w_next_pc = pc_plus4;
    if (jr_sel) begin
      w_next_pc = rs_value;
    end else if (jump) begin
      w_next_pc = w_jmp_tgt;
    end else if (branch_taken) begin
      w_next_pc = pc_plus4 + w_br_off;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        imem_req    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_VALID;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_ERR;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (advance) begin
          w_state_nxt = (w_next_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
        end
      end
      S_ERR: begin
        fetch_err = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Wait-cycle counter: cleared on each request, counts unanswered WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_REQ) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_WAIT && !imem_rvalid && r_cnt != LP_CNT_LAST) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // PC moves only when decode consumes the held word; a faulting target stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (r_state == S_VALID && advance) begin
      r_pc <= w_next_pc;
    end
  end

  // Capture the instruction word only while a response is awaited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 32'd0;
    end else if (r_state == S_WAIT && imem_rvalid) begin
      r_instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch vectors, scoreboard queues of expected addresses/words.
// Latency: memory answers one cycle after each request unless a vector withholds the response.
// Backpressure: advance is driven per vector; stalls hold it low while memory inputs toggle.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        branch_taken;
  logic        jump;
  logic        jr_sel;
  logic [31:0] rs_value;
  logic        fetch_err;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [31:0] exp_req[$];
  logic [63:0] exp_vld[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .advance      (advance),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr_sel       (jr_sel),
    .rs_value     (rs_value),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every request and every new valid word is checked against the scoreboard.
  initial begin
    logic        prev_vld;
    logic [63:0] e;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (imem_req === 1'b1) begin
          if (exp_req.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
          end else begin
            chk("imem_addr", imem_addr, exp_req.pop_front());
          end
        end
        if (instr_valid === 1'b1 && !prev_vld) begin
          if (exp_vld.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_valid: got pc %h instr %h expected none", pc, instr);
          end else begin
            e = exp_vld.pop_front();
            chk("valid_pc", pc, e[63:32]);
            chk("valid_instr", instr, e[31:0]);
            chk("valid_pc_plus4", pc_plus4, e[63:32] + 32'd4);
          end
        end
      end
      prev_vld = (instr_valid === 1'b1);
    end
  end

  // Expect a request at address a; optionally answer it one cycle later with word d.
  task automatic serve(input logic [31:0] a, input logic [31:0] d, input bit respond);
    bit seen;
    exp_req.push_back(a);
    if (respond) exp_vld.push_back({a, d});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (imem_req === 1'b1);
    end
    if (!seen) begin
      n_cmp++;
      n_mis++;
      $display("FAIL req_timeout: got no request expected addr %h", a);
    end else if (respond) begin
      @(posedge clk);
      #1 imem_rvalid = 1'b1;
      imem_rdata = d;
      @(posedge clk);
      #1 imem_rvalid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  // Consume the held word with the given control decisions.
  task automatic retire(input logic bt, input logic j, input logic jr, input logic [31:0] rs);
    advance = 1'b1;
    branch_taken = bt;
    jump = j;
    jr_sel = jr;
    rs_value = rs;
    @(posedge clk);
    #1 advance = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    jr_sel = 1'b0;
    rs_value = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
  endtask

  initial begin
    int t_v[4];
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    advance = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    jr_sel = 1'b0;
    rs_value = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cycle_req", {31'd0, imem_req}, 32'd0);

    // Sequential fetch at 0,4,8,12; the word at 12 jumps to 0x40.
    serve(32'h0, 32'h0000_0000, 1); t_v[0] = cyc; retire(0, 0, 0, 0);
    serve(32'h4, 32'h2108_0001, 1); t_v[1] = cyc; retire(0, 0, 0, 0);
    serve(32'h8, 32'h2108_0002, 1); t_v[2] = cyc; retire(0, 0, 0, 0);
    serve(32'hC, 32'h0800_0010, 1); t_v[3] = cyc; retire(0, 1, 0, 0);
    for (int k = 1; k < 4; k++) chk("valid_period", t_v[k] - t_v[k-1], 32'd3);

    // Branch back by 2 words: taken lands at 0x3C, not-taken at 0x44.
    serve(32'h40, 32'h1000_FFFE, 1); retire(1, 0, 0, 0);
    serve(32'h3C, 32'h0800_0010, 1); retire(0, 1, 0, 0);
    serve(32'h40, 32'h1000_FFFE, 1); retire(0, 0, 0, 0);

    // Stall in VALID for 5 cycles with noise on the memory inputs.
    serve(32'h44, 32'hA5A5_1234, 1);
    for (int k = 0; k < 5; k++) begin
      imem_rvalid = k[0];
      imem_rdata = 32'h1111_0000 + k;
      @(negedge clk);
      chk("stall_instr", instr, 32'hA5A5_1234);
      chk("stall_pc", pc, 32'h44);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    imem_rvalid = 1'b0;
    retire(0, 0, 1, 32'h1000_0000);

    // Jump keeps pc_plus4[31:28]; JR wins over jump.
    serve(32'h1000_0000, 32'h0800_0100, 1); retire(0, 1, 0, 0);
    serve(32'h1000_0400, 32'h0800_0100, 1); retire(0, 1, 1, 32'h200);
    serve(32'h200, 32'h03E0_0008, 1); retire(0, 0, 1, 32'hFFFF_FFFC);

    // Sequential wrap from the top of the address space.
    serve(32'hFFFF_FFFC, 32'h0000_0000, 1); retire(0, 0, 0, 0);
    serve(32'h0, 32'h2402_0005, 1);
    chk("wrap_no_err", {31'd0, fetch_err}, 32'd0);
    retire(0, 0, 0, 0);

    // Unanswered fetch at 4, reset asserted mid-WAIT.
    serve(32'h4, 32'h0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwait_rst");

    // Release with a stale response on the bus, then let the fetch time out.
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    exp_req.push_back(32'h0);
    @(negedge clk);
    chk("rel_idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wait_no_err", {31'd0, fetch_err}, 32'd0);
      chk("wait_no_valid", {31'd0, instr_valid}, 32'd0);
    end
    @(negedge clk);
    chk("timeout_err", {31'd0, fetch_err}, 32'd1);
    chk("timeout_pc", pc, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h7777_7777;
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0;
    chk("err_instr_kept", instr, 32'h0);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);

    // Misaligned JR target faults and stops fetching.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    serve(32'h0, 32'h03E0_0008, 1);
    retire(0, 1, 1, 32'h202);
    @(negedge clk);
    chk("misalign_err", {31'd0, fetch_err}, 32'd1);
    chk("misalign_pc", pc, 32'h202);
    chk("misalign_valid", {31'd0, instr_valid}, 32'd0);
    repeat (10) @(negedge clk);
    chk("misalign_no_req", {31'd0, imem_req}, 32'd0);
    chk("scoreboard_drained", exp_req.size() + exp_vld.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
